writeback_unit: RTL and testbench
=================================

# writeback_unit

Parametrised writeback stage for the five-stage pipeline. It contains the MW pipeline register and drives the single register-file write port. It arbitrates that port between in-order pipeline results (ALU, addi, lw, jal, setx) and out-of-order multiply/divide results, which wait in a small FIFO. It also substitutes status-register exception writes when an instruction overflows.

## Interface
- `DATA_W`, 32, datapath width.
- `REG_ADDR_W`, 5, register-address width.
- `STATUS_REG`, 30, rstatus index.
- `LINK_REG`, 31, jal link index.
- `MD_DEPTH`, 2, multdiv result FIFO depth (≥1).
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: an XM-stage instruction is present.
- `in_ir` in 32: instruction word.
- `in_alu_result` in DATA_W: XM ALU output.
- `in_mem_data` in DATA_W: load data.
- `in_pc_plus1` in DATA_W: PC+1 for jal.
- `in_exception` in 1: overflow on this instruction.
- `md_valid` in 1: a multdiv result is offered.
- `md_ready` out 1: the FIFO accepts the offer.
- `md_rd` in REG_ADDR_W: destination register.
- `md_result` in DATA_W: product or quotient.
- `md_is_div` in 1: 0 means mul, 1 means div.
- `md_exception` in 1: overflow or divide-by-zero.
- `ctrl_writeEnable` out 1: register-file write strobe.
- `ctrl_writeReg` out REG_ADDR_W: write address.
- `data_writeReg` out DATA_W: write data.
- `retire_count` out 32: count of committed writes.

## Operation
- Opcode decode uses `ir[31:27]`: R-type 00000, addi 00101, lw 01000, jal 00011, setx 10101. R-type ALU op is `ir[6:2]`: add 00000, sub 00001, mul 00110, div 00111.
- A pipeline slot writes when `in_valid` is 1 and the opcode is one of: R-type other than mul/div, addi, lw, jal, setx. R-type mul/div slots never write; their results arrive on the md port.
- Pipeline destination and data:
  - jal: register `LINK_REG`, data `in_pc_plus1`.
  - setx: register `STATUS_REG`, data `ir[26:0]` zero-extended.
  - lw: register `ir[26:22]`, data `in_mem_data`.
  - All other writing slots: register `ir[26:22]`, data `in_alu_result`.
- Pipeline exception: when `in_exception` is 1 on an add, addi or sub slot, write `STATUS_REG` with code add=1, addi=2, sub=3. `in_exception` is ignored on all other opcodes.
- Multdiv entry: written to `md_rd` with `md_result`. When `md_exception` is 1 it writes `STATUS_REG` instead, with code mul=4, div=5. The decision is made at push time and stored in the FIFO.
- Write-port arbitration, evaluated each cycle:
  - A writing pipeline slot always wins.
  - Otherwise the FIFO head is popped and written.
  - If neither applies, no write occurs.
- Any write whose final address is 0 is suppressed: `ctrl_writeEnable` stays 0 and `retire_count` does not increment. A suppressed FIFO pop still pops.
- FIFO rules:
  - A push occurs when `md_valid & md_ready`.
  - `md_ready` = (count < MD_DEPTH), computed from the registered count only. When the FIFO is full, a same-cycle pop does not raise `md_ready`.
  - A simultaneous push and pop leaves count unchanged.
  - An entry pushed in cycle N is poppable no earlier than cycle N+1, so there is no bypass.
  - Ordering is strictly FIFO.
- `retire_count` increments by 1 per cycle in which `ctrl_writeEnable` is 1 and wraps at 2^32.

## Timing
- The MW register captures `in_*` at clock edge N. The decision and outputs are registered at edge N+1, so pipeline writeback latency is 2 edges. `ctrl_*` and `data_writeReg` are flop outputs.
- A multdiv result pushed at edge N reaches the write-port outputs at edge N+2 at the earliest.
- Reset (synchronous, active-high) clears:
  - MW valid.
  - FIFO pointers and count, discarding entries. `md_ready`=1 in the cycle after reset.
  - `ctrl_writeEnable`=0, `ctrl_writeReg`=0, `data_writeReg`=0.
  - `retire_count`=0.
- Reset asserted mid-operation drops all pending writes, with no partial write. A push offered during reset is not accepted.

## Structure
- Package `wb_pkg`:
  - Opcode and ALU-op localparams.
  - Exception codes 1–5.
  - Typedef `wb_req_t` {we, addr, data}.
  - Function `pipe_decode(ir, alu, mem, pc1, exc)` returning `wb_req_t`.
- Sub-module `md_fifo`: parametrised on width and `MD_DEPTH`, with a circular buffer, a count, and ready/valid push and pop.
- Top level: MW register, decode, arbiter, output flops, retire counter.

## Test plan
- **Pipeline write:** add r3 with alu=0x0000_0007, no exception → the write to r3 with 7 appears 2 edges after `in_valid`; `retire_count`=1.
- **Overflow:** sub r4 with `in_exception`=1 → writes r30=3. addi r5 with exception → writes r30=2. lw with `in_exception`=1 → writes r(rd)=`in_mem_data`.
- **jal / setx / r0:** jal with pc_plus1=0x40 → r31=0x40. setx target 0x123 → r30=0x123. add to r0 → no write, counter unchanged.
- **Arbitration:** push mul r6=42 while three back-to-back writing ALU slots run → the r6 write appears at the first non-writing slot and no ALU write is lost.
- **FIFO full:** `MD_DEPTH`=2, push two results during continuous ALU writes → `md_ready`=0. A third offer is held and accepted only after a drain. Output order matches push order; a div with `md_exception` writes r30=5.
- **Reset mid-flight:** pulse reset with two FIFO entries and a valid MW slot → no writes follow; `retire_count`=0 and `md_ready`=1 on the next cycle.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage: ISA field encodings, exception
// codes, the write-port request type and the pipeline-slot decoder.
package wb_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 5;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_SETX  = 5'b10101;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00001;
    localparam logic [4:0] ALU_MUL  = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    localparam logic [WB_DATA_W-1:0] EXC_ADD  = 32'd1;
    localparam logic [WB_DATA_W-1:0] EXC_ADDI = 32'd2;
    localparam logic [WB_DATA_W-1:0] EXC_SUB  = 32'd3;
    localparam logic [WB_DATA_W-1:0] EXC_MUL  = 32'd4;
    localparam logic [WB_DATA_W-1:0] EXC_DIV  = 32'd5;

    typedef struct packed {
        logic                 we;
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_req_t;

    // Write request for one MW slot; validity is applied by the caller.
    function automatic wb_req_t pipe_decode(
        input logic [31:0]          ir,
        input logic [WB_DATA_W-1:0] alu,
        input logic [WB_DATA_W-1:0] mem,
        input logic [WB_DATA_W-1:0] pc1,
        input logic                 exc,
        input logic [WB_ADDR_W-1:0] status_reg = 5'd30,
        input logic [WB_ADDR_W-1:0] link_reg   = 5'd31
    );
        wb_req_t    req;
        logic [4:0] op;
        logic [4:0] aluop;
        op         = ir[31:27];
        aluop      = ir[6:2];
        req.we     = 1'b0;
        req.addr   = ir[26:22];
        req.data   = alu;
        case (op)
            OP_RTYPE: begin
                req.we = (aluop != ALU_MUL) && (aluop != ALU_DIV);
                if (exc && aluop == ALU_ADD) begin
                    req.addr = status_reg;
                    req.data = EXC_ADD;
                end else if (exc && aluop == ALU_SUB) begin
                    req.addr = status_reg;
                    req.data = EXC_SUB;
                end
            end
            OP_ADDI: begin
                req.we = 1'b1;
                if (exc) begin
                    req.addr = status_reg;
                    req.data = EXC_ADDI;
                end
            end
            OP_LW: begin
                req.we   = 1'b1;
                req.data = mem;
            end
            OP_JAL: begin
                req.we   = 1'b1;
                req.addr = link_reg;
                req.data = pc1;
            end
            OP_SETX: begin
                req.we   = 1'b1;
                req.addr = status_reg;
                req.data = WB_DATA_W'(ir[26:0]);
            end
            default: ;
        endcase
        return req;
    endfunction

endpackage

// File: rtl/writeback_unit_if.sv
// Bundle of the XM-stage inputs, multdiv result port and register-file write
// port seen by the writeback stage.
interface writeback_unit_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  in_valid;
    logic [31:0]           in_ir;
    logic [DATA_W-1:0]     in_alu_result;
    logic [DATA_W-1:0]     in_mem_data;
    logic [DATA_W-1:0]     in_pc_plus1;
    logic                  in_exception;

    logic                  md_valid;
    logic                  md_ready;
    logic [REG_ADDR_W-1:0] md_rd;
    logic [DATA_W-1:0]     md_result;
    logic                  md_is_div;
    logic                  md_exception;

    logic                  ctrl_writeEnable;
    logic [REG_ADDR_W-1:0] ctrl_writeReg;
    logic [DATA_W-1:0]     data_writeReg;
    logic [31:0]           retire_count;

    modport master (
        output in_valid, in_ir, in_alu_result, in_mem_data, in_pc_plus1, in_exception,
        output md_valid, md_rd, md_result, md_is_div, md_exception,
        input  md_ready,
        input  ctrl_writeEnable, ctrl_writeReg, data_writeReg, retire_count
    );

    modport slave (
        input  in_valid, in_ir, in_alu_result, in_mem_data, in_pc_plus1, in_exception,
        input  md_valid, md_rd, md_result, md_is_div, md_exception,
        output md_ready,
        output ctrl_writeEnable, ctrl_writeReg, data_writeReg, retire_count
    );

endinterface

// File: rtl/writeback_unit_md_fifo.sv
// Circular-buffer FIFO holding multdiv write requests until the write port is
// free. An entry is never popped in the cycle right after it was pushed.
module md_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [WIDTH-1:0] push_data,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] pop_data
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             fresh_q;
    logic             push;
    logic             pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign push_ready = (count < CNT_W'(DEPTH));
    // Only the newest entry can be fresh, so the head is held back solely when
    // it is the sole entry and was written at the previous edge.
    assign pop_valid  = (count > CNT_W'(1)) || ((count == CNT_W'(1)) && !fresh_q);
    assign pop_data   = mem[rd_ptr];
    assign push       = push_valid & push_ready;
    assign pop        = pop_ready & pop_valid;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            fresh_q <= 1'b0;
        end else begin
            fresh_q <= push;
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: MW pipeline register, pipeline/multdiv arbitration of the
// single register-file write port, and the committed-write counter.
module writeback_unit
    import wb_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int STATUS_REG = 30,
    parameter int LINK_REG   = 31,
    parameter int MD_DEPTH   = 2
) (
    input logic              clock,
    input logic              reset,
    writeback_unit_if.slave  wb
);
    localparam int ENTRY_W = REG_ADDR_W + DATA_W;

    logic                  mw_valid;
    logic [31:0]           mw_ir;
    logic [DATA_W-1:0]     mw_alu;
    logic [DATA_W-1:0]     mw_mem;
    logic [DATA_W-1:0]     mw_pc1;
    logic                  mw_exc;

    logic [ENTRY_W-1:0]    md_entry;
    logic [ENTRY_W-1:0]    head;
    logic                  head_valid;
    logic                  pop_ready;

    wb_req_t               pipe_req;
    logic                  pipe_we;
    logic                  cand_we;
    logic [REG_ADDR_W-1:0] cand_addr;
    logic [DATA_W-1:0]     cand_data;
    logic                  commit;

    always_ff @(posedge clock) begin
        if (reset) begin
            mw_valid <= 1'b0;
        end else begin
            mw_valid <= wb.in_valid;
        end
    end

    always_ff @(posedge clock) begin
        mw_ir  <= wb.in_ir;
        mw_alu <= wb.in_alu_result;
        mw_mem <= wb.in_mem_data;
        mw_pc1 <= wb.in_pc_plus1;
        mw_exc <= wb.in_exception;
    end

    // Exception substitution is resolved before the entry is queued.
    always_comb begin
        md_entry = {wb.md_rd, wb.md_result};
        if (wb.md_exception) begin
            md_entry = {REG_ADDR_W'(STATUS_REG),
                        wb.md_is_div ? DATA_W'(EXC_DIV) : DATA_W'(EXC_MUL)};
        end
    end

    md_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (MD_DEPTH)
    ) u_md_fifo (
        .clk        (clock),
        .rst        (reset),
        .push_valid (wb.md_valid),
        .push_ready (wb.md_ready),
        .push_data  (md_entry),
        .pop_valid  (head_valid),
        .pop_ready  (pop_ready),
        .pop_data   (head)
    );

    always_comb begin
        pipe_req  = pipe_decode(mw_ir, WB_DATA_W'(mw_alu), WB_DATA_W'(mw_mem),
                                WB_DATA_W'(mw_pc1), mw_exc,
                                WB_ADDR_W'(STATUS_REG), WB_ADDR_W'(LINK_REG));
        pipe_we   = mw_valid & pipe_req.we;
        pop_ready = !pipe_we;
        cand_we   = 1'b0;
        cand_addr = '0;
        cand_data = '0;
        if (pipe_we) begin
            cand_we   = 1'b1;
            cand_addr = REG_ADDR_W'(pipe_req.addr);
            cand_data = DATA_W'(pipe_req.data);
        end else if (head_valid) begin
            cand_we   = 1'b1;
            cand_addr = head[ENTRY_W-1 -: REG_ADDR_W];
            cand_data = head[DATA_W-1:0];
        end
        // r0 writes still consume their slot or FIFO entry but never commit.
        commit = cand_we && (cand_addr != '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wb.ctrl_writeEnable <= 1'b0;
            wb.ctrl_writeReg    <= '0;
            wb.data_writeReg    <= '0;
            wb.retire_count     <= '0;
        end else begin
            wb.ctrl_writeEnable <= commit;
            wb.ctrl_writeReg    <= cand_addr;
            wb.data_writeReg    <= cand_data;
            wb.retire_count     <= wb.retire_count + 32'(commit);
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: a decode vector table plus hand-timed
// sequences for arbitration, FIFO backpressure and mid-flight reset.
module tb_writeback_unit;
    import wb_pkg::*;

    logic clk;
    logic rst;
    int   tests;
    int   failed;
    logic [31:0] exp_retire;

    writeback_unit_if #(.DATA_W(32), .REG_ADDR_W(5)) wb ();

    writeback_unit #(
        .DATA_W     (32),
        .REG_ADDR_W (5),
        .STATUS_REG (30),
        .LINK_REG   (31),
        .MD_DEPTH   (2)
    ) dut (
        .clock (clk),
        .reset (rst),
        .wb    (wb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] ir;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [31:0] pc1;
        logic        exc;
        logic        exp_we;
        logic [4:0]  exp_reg;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] r_ir(input logic [4:0] rd, input logic [4:0] aluop);
        return {OP_RTYPE, rd, 5'd1, 5'd2, 5'd0, aluop, 2'b00};
    endfunction

    function automatic logic [31:0] i_ir(input logic [4:0] op, input logic [4:0] rd);
        return {op, rd, 5'd1, 17'h00003};
    endfunction

    function automatic logic [31:0] j_ir(input logic [4:0] op, input logic [26:0] tgt);
        return {op, tgt};
    endfunction

    function automatic vec_t mkv(input logic v, input logic [31:0] ir, input logic [31:0] alu,
                                 input logic [31:0] mem, input logic [31:0] pc1, input logic exc,
                                 input logic ew, input logic [4:0] er, input logic [31:0] ed);
        vec_t t;
        t.valid = v; t.ir = ir; t.alu = alu; t.mem = mem; t.pc1 = pc1; t.exc = exc;
        t.exp_we = ew; t.exp_reg = er; t.exp_data = ed;
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic ew, input logic [4:0] er,
                             input logic [31:0] ed);
        check({name, "_we"}, 32'(wb.ctrl_writeEnable), 32'(ew));
        if (ew) begin
            check({name, "_reg"}, 32'(wb.ctrl_writeReg), 32'(er));
            check({name, "_data"}, wb.data_writeReg, ed);
            exp_retire++;
        end
        check({name, "_retire"}, wb.retire_count, exp_retire);
    endtask

    task automatic drive_pipe(input logic v, input logic [31:0] ir, input logic [31:0] alu,
                              input logic [31:0] mem, input logic [31:0] pc1, input logic exc);
        wb.in_valid = v; wb.in_ir = ir; wb.in_alu_result = alu;
        wb.in_mem_data = mem; wb.in_pc_plus1 = pc1; wb.in_exception = exc;
    endtask

    task automatic drive_md(input logic v, input logic [4:0] rd, input logic [31:0] res,
                            input logic is_div, input logic exc);
        wb.md_valid = v; wb.md_rd = rd; wb.md_result = res;
        wb.md_is_div = is_div; wb.md_exception = exc;
    endtask

    // FIFO-full sequence expectations, indexed by cycle step
    logic        b_ready [11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic        b_we    [11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [4:0]  b_reg   [11] = '{5'd0, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd7, 5'd30, 5'd0, 5'd9, 5'd0};
    logic [31:0] b_data  [11] = '{32'd0, 32'd200, 32'd201, 32'd202, 32'd203, 32'd204,
                                  32'd70, 32'd5, 32'd0, 32'd90, 32'd0};

    initial begin
        logic accepted;
        tests = 0;
        failed = 0;
        exp_retire = '0;
        rst = 1'b1;
        drive_pipe(1'b0, '0, '0, '0, '0, 1'b0);
        drive_md(1'b0, '0, '0, 1'b0, 1'b0);

        tick();
        tick();
        check("rst_we", 32'(wb.ctrl_writeEnable), 32'd0);
        check("rst_reg", 32'(wb.ctrl_writeReg), 32'd0);
        check("rst_data", wb.data_writeReg, 32'd0);
        check("rst_retire", wb.retire_count, 32'd0);
        check("rst_md_ready", 32'(wb.md_ready), 32'd1);
        rst = 1'b0;
        tick();

        vecs.push_back(mkv(1, r_ir(5'd3, ALU_ADD), 32'h7, 32'h0, 32'h0, 0, 1, 5'd3, 32'h7));
        vecs.push_back(mkv(1, r_ir(5'd4, ALU_SUB), 32'h8000_0000, 32'h0, 32'h0, 1, 1, 5'd30, 32'd3));
        vecs.push_back(mkv(1, i_ir(OP_ADDI, 5'd5), 32'h7FFF_FFFF, 32'h0, 32'h0, 1, 1, 5'd30, 32'd2));
        vecs.push_back(mkv(1, r_ir(5'd2, ALU_ADD), 32'h1, 32'h0, 32'h0, 1, 1, 5'd30, 32'd1));
        vecs.push_back(mkv(1, i_ir(OP_LW, 5'd7), 32'h100, 32'hDEAD_BEEF, 32'h0, 1, 1, 5'd7, 32'hDEAD_BEEF));
        vecs.push_back(mkv(1, j_ir(OP_JAL, 27'h55), 32'h9, 32'h0, 32'h40, 0, 1, 5'd31, 32'h40));
        vecs.push_back(mkv(1, j_ir(OP_SETX, 27'h123), 32'h9, 32'h0, 32'h0, 0, 1, 5'd30, 32'h123));
        vecs.push_back(mkv(1, r_ir(5'd0, ALU_ADD), 32'h5, 32'h0, 32'h0, 0, 0, 5'd0, 32'h0));
        vecs.push_back(mkv(1, r_ir(5'd6, ALU_MUL), 32'h11, 32'h0, 32'h0, 0, 0, 5'd0, 32'h0));
        vecs.push_back(mkv(1, r_ir(5'd6, ALU_DIV), 32'h11, 32'h0, 32'h0, 1, 0, 5'd0, 32'h0));
        vecs.push_back(mkv(1, i_ir(OP_ADDI, 5'd9), 32'h1234, 32'h0, 32'h0, 0, 1, 5'd9, 32'h1234));
        vecs.push_back(mkv(1, r_ir(5'd10, ALU_SUB), 32'hFFFF_FFFF, 32'h0, 32'h0, 0, 1, 5'd10, 32'hFFFF_FFFF));
        vecs.push_back(mkv(1, i_ir(OP_LW, 5'd0), 32'h4, 32'h77, 32'h0, 0, 0, 5'd0, 32'h0));
        vecs.push_back(mkv(1, r_ir(5'd11, 5'b00010), 32'hA5A5, 32'h0, 32'h0, 1, 1, 5'd11, 32'hA5A5));
        vecs.push_back(mkv(1, i_ir(5'b00111, 5'd12), 32'h3, 32'h0, 32'h0, 0, 0, 5'd0, 32'h0));
        vecs.push_back(mkv(0, r_ir(5'd12, ALU_ADD), 32'h3, 32'h0, 32'h0, 0, 0, 5'd0, 32'h0));
        vecs.push_back(mkv(1, j_ir(OP_SETX, 27'h7FF_FFFF), 32'h0, 32'h0, 32'h0, 0, 1, 5'd30, 32'h07FF_FFFF));
        vecs.push_back(mkv(1, i_ir(OP_ADDI, 5'd0), 32'h0, 32'h0, 32'h0, 1, 1, 5'd30, 32'd2));

        for (int i = 0; i < vecs.size(); i++) begin
            drive_pipe(vecs[i].valid, vecs[i].ir, vecs[i].alu, vecs[i].mem, vecs[i].pc1, vecs[i].exc);
            tick();
            drive_pipe(1'b0, '0, '0, '0, '0, 1'b0);
            tick();
            check_out($sformatf("vec%0d", i), vecs[i].exp_we, vecs[i].exp_reg, vecs[i].exp_data);
        end

        // Arbitration: mul r6 pushed alongside three back-to-back ALU writes
        check("arb_md_ready", 32'(wb.md_ready), 32'd1);
        drive_md(1'b1, 5'd6, 32'd42, 1'b0, 1'b0);
        drive_pipe(1'b1, r_ir(5'd20, ALU_ADD), 32'd100, '0, '0, 1'b0);
        tick();
        drive_md(1'b0, '0, '0, 1'b0, 1'b0);
        check_out("arb_e0", 1'b0, 5'd0, 32'd0);
        drive_pipe(1'b1, r_ir(5'd21, ALU_ADD), 32'd101, '0, '0, 1'b0);
        tick();
        check_out("arb_e1", 1'b1, 5'd20, 32'd100);
        drive_pipe(1'b1, r_ir(5'd22, ALU_ADD), 32'd102, '0, '0, 1'b0);
        tick();
        check_out("arb_e2", 1'b1, 5'd21, 32'd101);
        drive_pipe(1'b0, '0, '0, '0, '0, 1'b0);
        tick();
        check_out("arb_e3", 1'b1, 5'd22, 32'd102);
        tick();
        check_out("arb_e4", 1'b1, 5'd6, 32'd42);
        tick();
        check_out("arb_e5", 1'b0, 5'd0, 32'd0);

        // FIFO full: two pushes under continuous ALU writes, third offer held
        accepted = 1'b0;
        for (int k = 0; k < 11; k++) begin
            drive_pipe(k <= 4, r_ir(5'(12 + k), ALU_ADD), 32'(200 + k), '0, '0, 1'b0);
            if (k == 0)
                drive_md(1'b1, 5'd7, 32'd70, 1'b0, 1'b0);
            else if (k == 1)
                drive_md(1'b1, 5'd8, 32'h55, 1'b1, 1'b1);
            else if (!accepted)
                drive_md(1'b1, 5'd9, 32'd90, 1'b0, 1'b0);
            else
                drive_md(1'b0, '0, '0, 1'b0, 1'b0);
            check($sformatf("full_ready%0d", k), 32'(wb.md_ready), 32'(b_ready[k]));
            if (k >= 2 && wb.md_valid && wb.md_ready) accepted = 1'b1;
            tick();
            check_out($sformatf("full_e%0d", k), b_we[k], b_reg[k], b_data[k]);
        end
        drive_md(1'b0, '0, '0, 1'b0, 1'b0);

        // Reset with two queued entries and a valid MW slot
        drive_pipe(1'b1, r_ir(5'd12, ALU_ADD), 32'd300, '0, '0, 1'b0);
        drive_md(1'b1, 5'd7, 32'd77, 1'b0, 1'b0);
        tick();
        check_out("rmf_e0", 1'b0, 5'd0, 32'd0);
        drive_pipe(1'b1, r_ir(5'd13, ALU_ADD), 32'd301, '0, '0, 1'b0);
        drive_md(1'b1, 5'd8, 32'd88, 1'b0, 1'b0);
        tick();
        check_out("rmf_e1", 1'b1, 5'd12, 32'd300);
        drive_pipe(1'b1, r_ir(5'd14, ALU_ADD), 32'd302, '0, '0, 1'b0);
        drive_md(1'b0, '0, '0, 1'b0, 1'b0);
        tick();
        check_out("rmf_e2", 1'b1, 5'd13, 32'd301);
        rst = 1'b1;
        drive_pipe(1'b0, '0, '0, '0, '0, 1'b0);
        drive_md(1'b1, 5'd9, 32'd99, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        drive_md(1'b0, '0, '0, 1'b0, 1'b0);
        exp_retire = '0;
        check("rmf_reg", 32'(wb.ctrl_writeReg), 32'd0);
        check("rmf_data", wb.data_writeReg, 32'd0);
        check("rmf_md_ready", 32'(wb.md_ready), 32'd1);
        check_out("rmf_rst", 1'b0, 5'd0, 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check_out($sformatf("rmf_idle%0d", k), 1'b0, 5'd0, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
